dds_wave_engine: RTL and testbench
==================================

// Module: dds_wave_engine
// PURPOSE
// Downstream consumer of the UART protocol decoder. Holds the control/tuning register file
// written via wr_en_i/reg_addr_i/reg_data_i, and the waveform RAM filled via wave_*_i.
// Runs a phase accumulator that indexes the RAM to produce one scaled 8-bit DDS sample per clk.
// Returns register contents on rd_data_o for decoder read commands.
// PARAMETERS
// ADDR_WIDTH  12    wave RAM address width; RAM depth = 2**ADDR_WIDTH
// ACC_WIDTH   32    phase accumulator width (>= ADDR_WIDTH+8)
// PORTS
// clk             in   1           clock
// rst_n           in   1           asynchronous, active-low reset
// wave_addr_i     in   ADDR_WIDTH  RAM write address
// wave_data_i     in   8           RAM write data (offset-binary sample)
// wave_load_en_i  in   1           RAM write enable, level; writes every cycle while high
// wr_en_i         in   1           register write request, level; acted on at rising edge only
// reg_addr_i      in   8           register address (write and read)
// reg_data_i      in   8           register write data
// rd_data_o       out  8           combinational readback of register at reg_addr_i
// sample_o        out  8           scaled DDS output sample, registered
// sample_valid_o  out  1           high while sample_o carries live samples
// BEHAVIOUR
// Register map (unmapped writes ignored, unmapped reads 0x00):
// - 0x00 CTRL: bit0 RUN (R/W); bit1 PCLR (W only, self-clearing, reads 0).
// - 0x01..0x04 FTW byte0..3 (LSB first) go into a shadow register.
// - Write to 0x04 commits the full 32-bit shadow to the active FTW in the same cycle.
// - FTW reads return the shadow. If ACC_WIDTH<32, the FTW is truncated to ACC_WIDTH LSBs.
// - 0x05/0x06 POFF low/high byte: phase offset in RAM-address units; only ADDR_WIDTH LSBs used.
// - 0x07 AMP: default 0xFF.
// - 0x08 STATUS (RO): bits[1:0] = FSM state code.
// Write strobe:
// - wr_q is the registered wr_en_i. A register write occurs when wr_en_i && !wr_q.
// - A level held high for many cycles therefore writes once.
// Reset:
// - All registers, acc, pipeline, sample_o, sample_valid_o and wr_q go to 0, except AMP=0xFF.
// - rd_data_o follows the registers.
// - RAM array is not reset; contents survive rst_n.
// - Reset mid-run stops output in the same cycle; RUN must be rewritten afterwards.
// FSM (STATUS code):
// - S_IDLE(0): acc held, sample_o holds its last value, sample_valid_o=0.
//   RUN=1 -> S_FILL.
// - S_FILL(1): pipeline advancing; 2-bit counter counts 3 cycles -> S_RUN. sample_valid_o=0.
// - S_RUN(2): sample_valid_o=1.
// - RUN=0 from any state -> S_IDLE on the next clk.
// Pipeline (advances only in S_FILL/S_RUN):
// - P0: acc <= acc + FTW, modulo 2**ACC_WIDTH (wraps silently).
// - P1: raddr <= acc[ACC_WIDTH-1 -: ADDR_WIDTH] + POFF, modulo 2**ADDR_WIDTH.
// - P2: rdata <= ram[raddr]. Read-before-write: same-address write in that cycle returns old data.
// - P3: sample_o <= (rdata * (AMP+1)) >> 8, using a 17-bit product. AMP=0xFF gives rdata unchanged.
// Latency: an acc value appears at sample_o 3 clk later.
// PCLR:
// - Takes effect at the write strobe edge: acc <= 0, overriding that cycle's increment.
// - The pipeline is not flushed.
// FTW commit: the new FTW is used by the P0 add in the cycle after the 0x04 write.
// RAM loads are accepted in every state, including S_RUN. They never stall playback.
// Register write and RAM write in the same cycle are independent; both take effect.
// TESTING
// 1. Reset: assert rst_n=0 mid-run -> sample_o=0, sample_valid_o=0, rd_data_o@0x07=0xFF;
//    RAM pattern is still readable after re-enabling.
// 2. Load ram[i]=i[7:0] for i=0..4095. Write FTW=0x01000000, AMP=0xFF, RUN=1.
//    Expect valid 4 clk after the RUN edge, then sample_o = 0x00,0x10,0x20,... (step 16),
//    wrapping 0xF0 -> 0x00.
// 3. Hold wr_en_i high 10 cycles with addr 0x07, data 0x7F -> exactly one write.
//    Samples are halved: ram 0x80 -> 0x40.
// 4. Write FTW bytes 0x01..0x03 while running -> step unchanged.
//    Write 0x04 -> new step seen 4 clk later.
// 5. POFF=0x0010 with FTW=0 after PCLR -> sample_o constant = ram[16].
//    Then write RUN=0 -> state 0, valid drops next clk, sample_o holds.
// 6. During S_RUN, overwrite ram[0x100] while P2 reads it -> that sample is the old value,
//    the next pass returns the new value. Reads of 0x09 -> 0x00.

Source files
------------

// File: rtl/dds_wave_engine_if.sv
// Bus bundle between the UART protocol decoder and the DDS wave engine:
// register read/write access plus the waveform RAM load port.
interface dds_wave_engine_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] wave_addr_i;
  logic [7:0]            wave_data_i;
  logic                  wave_load_en_i;
  logic                  wr_en_i;
  logic [7:0]            reg_addr_i;
  logic [7:0]            reg_data_i;
  logic [7:0]            rd_data_o;

  // Decoder side: drives requests, receives readback.
  modport master (
    output wave_addr_i, wave_data_i, wave_load_en_i,
    output wr_en_i, reg_addr_i, reg_data_i,
    input  rd_data_o
  );

  // Engine side: receives requests, returns readback.
  modport slave (
    input  wave_addr_i, wave_data_i, wave_load_en_i,
    input  wr_en_i, reg_addr_i, reg_data_i,
    output rd_data_o
  );
endinterface

// File: rtl/dds_wave_engine.sv
// DDS wave engine: register file (CTRL/FTW/POFF/AMP/STATUS), waveform RAM,
// and a 4-stage phase-accumulator pipeline producing one scaled 8-bit
// sample per clock while running.
module dds_wave_engine #(
  parameter int ADDR_WIDTH = 12,
  parameter int ACC_WIDTH  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  dds_wave_engine_if.slave    bus,
  output logic [7:0]          sample_o,
  output logic                sample_valid_o
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------
  // Write strobe: a held wr_en_i level produces a single write.
  // ---------------------------------------------------------------------
  logic wr_q;
  logic wr_stb_s;

  assign wr_stb_s = bus.wr_en_i & ~wr_q;

  // Remember last cycle's write request level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q <= 1'b0;
    end else begin
      wr_q <= bus.wr_en_i;
    end
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic        run_q,    run_d;
  logic [31:0] ftw_sh_q, ftw_sh_d;   // shadow, visible on readback
  logic [31:0] ftw_q,    ftw_d;      // active tuning word
  logic [15:0] poff_q,   poff_d;
  logic [7:0]  amp_q,    amp_d;
  logic        pclr_s;

  // Decode one register write per strobe; writing FTW byte 3 commits the shadow.
  always_comb begin
    run_d    = run_q;
    ftw_sh_d = ftw_sh_q;
    ftw_d    = ftw_q;
    poff_d   = poff_q;
    amp_d    = amp_q;
    pclr_s   = 1'b0;
    if (wr_stb_s) begin
      case (bus.reg_addr_i)
        8'h00: begin
          run_d  = bus.reg_data_i[0];
          pclr_s = bus.reg_data_i[1];
        end
        8'h01: ftw_sh_d[7:0]   = bus.reg_data_i;
        8'h02: ftw_sh_d[15:8]  = bus.reg_data_i;
        8'h03: ftw_sh_d[23:16] = bus.reg_data_i;
        8'h04: begin
          ftw_sh_d[31:24] = bus.reg_data_i;
          ftw_d           = {bus.reg_data_i, ftw_sh_q[23:0]};
        end
        8'h05: poff_d[7:0]  = bus.reg_data_i;
        8'h06: poff_d[15:8] = bus.reg_data_i;
        8'h07: amp_d        = bus.reg_data_i;
        default: begin
          run_d = run_q;
        end
      endcase
    end else begin
      pclr_s = 1'b0;
    end
  end

  // Register file state; AMP comes out of reset at full scale.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q    <= 1'b0;
      ftw_sh_q <= 32'd0;
      ftw_q    <= 32'd0;
      poff_q   <= 16'd0;
      amp_q    <= 8'hFF;
    end else begin
      run_q    <= run_d;
      ftw_sh_q <= ftw_sh_d;
      ftw_q    <= ftw_d;
      poff_q   <= poff_d;
      amp_q    <= amp_d;
    end
  end

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [1:0]  fill_cnt_q, fill_cnt_d;
  logic        adv_s;
  logic        valid_d;
  logic        valid_q;

  // FSM state and fill counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      fill_cnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // Next state: dropping RUN always returns to idle; fill lasts three cycles.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = 2'd0;
    if (!run_q) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_FILL;
        S_FILL: begin
          if (fill_cnt_q == 2'd2) begin
            state_d = S_RUN;
          end else begin
            state_d    = S_FILL;
            fill_cnt_d = fill_cnt_q + 2'd1;
          end
        end
        S_RUN:   state_d = S_RUN;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM outputs: pipeline advance enable and next valid flag.
  always_comb begin
    adv_s   = (state_q == S_FILL) || (state_q == S_RUN);
    valid_d = (state_d == S_RUN);
  end

  // ---------------------------------------------------------------------
  // Waveform RAM (not reset; contents survive rst_n)
  // ---------------------------------------------------------------------
  logic [7:0] ram [DEPTH];

  // RAM load port, accepted in every state.
  always_ff @(posedge clk) begin
    if (bus.wave_load_en_i) begin
      ram[bus.wave_addr_i] <= bus.wave_data_i;
    end
  end

  // ---------------------------------------------------------------------
  // Pipeline: P0 accumulate, P1 address, P2 RAM read, P3 scale
  // ---------------------------------------------------------------------
  logic [ACC_WIDTH-1:0]  acc_q,    acc_d;
  logic [ACC_WIDTH-1:0]  ftw_acc_s;
  logic [ADDR_WIDTH-1:0] raddr_q,  raddr_d;
  logic [7:0]            rdata_q;
  logic [16:0]           prod_s;
  logic [7:0]            sample_q, sample_d;

  assign ftw_acc_s = ACC_WIDTH'(ftw_q);

  // Next-state for accumulate, address and scale stages; PCLR beats the increment.
  always_comb begin
    prod_s = 17'(rdata_q) * 17'({1'b0, amp_q} + 9'd1);
    if (pclr_s) begin
      acc_d = '0;
    end else if (adv_s) begin
      acc_d = acc_q + ftw_acc_s;
    end else begin
      acc_d = acc_q;
    end
    if (adv_s) begin
      raddr_d  = acc_q[ACC_WIDTH-1 -: ADDR_WIDTH] + ADDR_WIDTH'(poff_q);
      sample_d = 8'(prod_s >> 8);
    end else begin
      raddr_d  = raddr_q;
      sample_d = sample_q;
    end
  end

  // Pipeline registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      raddr_q  <= '0;
      sample_q <= 8'd0;
      valid_q  <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      raddr_q  <= raddr_d;
      sample_q <= sample_d;
      valid_q  <= valid_d;
    end
  end

  // RAM read stage; a same-cycle load to this address returns the old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= 8'd0;
    end else if (adv_s) begin
      rdata_q <= ram[raddr_q];
    end else begin
      rdata_q <= rdata_q;
    end
  end

  assign sample_o       = sample_q;
  assign sample_valid_o = valid_q;

  // ---------------------------------------------------------------------
  // Register readback (combinational on reg_addr_i)
  // ---------------------------------------------------------------------
  logic [7:0] rd_data_s;

  // Readback mux; PCLR and unmapped addresses read as zero, FTW reads the shadow.
  always_comb begin
    case (bus.reg_addr_i)
      8'h00:   rd_data_s = {7'd0, run_q};
      8'h01:   rd_data_s = ftw_sh_q[7:0];
      8'h02:   rd_data_s = ftw_sh_q[15:8];
      8'h03:   rd_data_s = ftw_sh_q[23:16];
      8'h04:   rd_data_s = ftw_sh_q[31:24];
      8'h05:   rd_data_s = poff_q[7:0];
      8'h06:   rd_data_s = poff_q[15:8];
      8'h07:   rd_data_s = amp_q;
      8'h08:   rd_data_s = {6'd0, state_q};
      default: rd_data_s = 8'h00;
    endcase
  end

  assign bus.rd_data_o = rd_data_s;

endmodule

// File: tb/tb_dds_wave_engine.sv
// Self-checking bench for dds_wave_engine: register table vectors plus a
// sample scoreboard fed by the stimulus and drained by the output stream.
module tb_dds_wave_engine;

  localparam int AW = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] sample_o;
  logic       sample_valid_o;

  dds_wave_engine_if #(.ADDR_WIDTH(AW)) bus ();

  dds_wave_engine #(.ADDR_WIDTH(AW), .ACC_WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .sample_o       (sample_o),
    .sample_valid_o (sample_valid_o)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  int         edge_n = 0;
  int         e0     = -1000;
  bit         chk_en = 1'b0;
  bit         lat_en = 1'b0;
  logic [7:0] exp_q [$];

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] exp;
  } reg_vec_t;

  reg_vec_t vec [14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    bus.reg_addr_i = a;
    #1;
    d = bus.rd_data_o;
  endtask

  // One clock; samples at the falling edge and scores live samples.
  task automatic cyc();
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    edge_n++;
    if (lat_en && edge_n == e0 + 3) check("fill_no_valid", {31'd0, sample_valid_o}, 32'd0);
    if (lat_en && edge_n == e0 + 4) check("first_valid", {31'd0, sample_valid_o}, 32'd1);
    if (chk_en && sample_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sample_extra: got 0x%0h expected no sample (t=%0t)", sample_o, $time);
      end else begin
        e = exp_q.pop_front();
        check("sample", {24'd0, sample_o}, {24'd0, e});
      end
    end
  endtask

  task automatic reg_write(input logic [7:0] a, input logic [7:0] d);
    bus.wr_en_i    = 1'b1;
    bus.reg_addr_i = a;
    bus.reg_data_i = d;
    cyc();
    bus.wr_en_i = 1'b0;
    cyc();
  endtask

  // PCLR + RUN: phase starts at 0, first valid sample 4 clocks after this edge.
  task automatic restart();
    chk_en         = 1'b1;
    bus.wr_en_i    = 1'b1;
    bus.reg_addr_i = 8'h00;
    bus.reg_data_i = 8'h03;
    cyc();
    e0          = edge_n;
    lat_en      = 1'b1;
    bus.wr_en_i = 1'b0;
    cyc();
  endtask

  task automatic run_until(input int t);
    while (edge_n < t) cyc();
  endtask

  task automatic end_phase();
    chk_en = 1'b0;
    lat_en = 1'b0;
    check("drain", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  task automatic stop_run();
    reg_write(8'h00, 8'h00);
    cyc();
  endtask

  // Pattern ram[i]=i[7:0] with a 16-index step, except ram[0x100] overwritten to 0xAB.
  function automatic logic [7:0] pat_sample(input int k, input bit old_first);
    int idx;
    idx = (16 * k) % 4096;
    if (idx == 256) return (old_first && k == 16) ? 8'h00 : 8'hAB;
    return 8'(idx);
  endfunction

  initial begin
    logic [7:0] d;
    logic [7:0] v;

    vec[0]  = '{8'h01, 8'h78, 8'h78};
    vec[1]  = '{8'h01, 8'h00, 8'h00};
    vec[2]  = '{8'h02, 8'h00, 8'h00};
    vec[3]  = '{8'h03, 8'h00, 8'h00};
    vec[4]  = '{8'h04, 8'h01, 8'h01};
    vec[5]  = '{8'h05, 8'hA5, 8'hA5};
    vec[6]  = '{8'h05, 8'h00, 8'h00};
    vec[7]  = '{8'h06, 8'h3C, 8'h3C};
    vec[8]  = '{8'h06, 8'h00, 8'h00};
    vec[9]  = '{8'h07, 8'hFF, 8'hFF};
    vec[10] = '{8'h09, 8'h5A, 8'h00};
    vec[11] = '{8'h08, 8'h33, 8'h00};
    vec[12] = '{8'h00, 8'h02, 8'h00};
    vec[13] = '{8'hFF, 8'h11, 8'h00};

    bus.wave_addr_i    = '0;
    bus.wave_data_i    = 8'h00;
    bus.wave_load_en_i = 1'b0;
    bus.wr_en_i        = 1'b0;
    bus.reg_addr_i     = 8'h00;
    bus.reg_data_i     = 8'h00;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    check("rst_sample", {24'd0, sample_o}, 32'd0);
    check("rst_valid", {31'd0, sample_valid_o}, 32'd0);
    read_reg(8'h07, d); check("rst_amp", {24'd0, d}, 32'h0000_00FF);
    read_reg(8'h00, d); check("rst_ctrl", {24'd0, d}, 32'd0);
    read_reg(8'h08, d); check("rst_status", {24'd0, d}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Load the ramp pattern
    for (int i = 0; i < 4096; i++) begin
      bus.wave_load_en_i = 1'b1;
      bus.wave_addr_i    = i[11:0];
      bus.wave_data_i    = i[7:0];
      cyc();
    end
    bus.wave_load_en_i = 1'b0;
    cyc();

    // Register map vectors (leaves FTW=0x01000000, AMP=0xFF, POFF=0)
    for (int i = 0; i < 14; i++) begin
      reg_write(vec[i].addr, vec[i].data);
      read_reg(vec[i].addr, d);
      check($sformatf("reg_%02h", vec[i].addr), {24'd0, d}, {24'd0, vec[i].exp});
    end

    // Ramp playback, step 16, wraps 0xF0 -> 0x00
    for (int k = 0; k < 20; k++) exp_q.push_back(8'(16 * k));
    restart();
    run_until(e0 + 3 + 20);
    end_phase();
    stop_run();

    // Held write strobe: exactly one write
    bus.wr_en_i    = 1'b1;
    bus.reg_addr_i = 8'h07;
    bus.reg_data_i = 8'h7F;
    repeat (10) cyc();
    bus.wr_en_i = 1'b0;
    cyc();
    read_reg(8'h07, d); check("hold_amp", {24'd0, d}, 32'h0000_007F);
    bus.wr_en_i    = 1'b1;
    bus.reg_addr_i = 8'h01;
    for (int j = 0; j < 6; j++) begin
      bus.reg_data_i = 8'((j + 1) * 17);
      cyc();
    end
    bus.wr_en_i = 1'b0;
    cyc();
    read_reg(8'h01, d); check("hold_once", {24'd0, d}, 32'h0000_0011);
    reg_write(8'h01, 8'h00);

    // Half amplitude: ram 0x80 -> 0x40
    for (int k = 0; k < 16; k++) begin
      v = 8'(16 * k);
      exp_q.push_back(8'((int'(v) * 128) >> 8));
    end
    restart();
    run_until(e0 + 3 + 16);
    end_phase();
    stop_run();
    reg_write(8'h07, 8'hFF);

    // FTW shadow bytes do not affect the step until byte 3 commits
    for (int k = 0; k < 16; k++) begin
      if (k <= 7) exp_q.push_back(8'(16 * k));
      else        exp_q.push_back(8'(112 + 8 * (k - 7)));
    end
    restart();
    reg_write(8'h01, 8'h00);
    reg_write(8'h02, 8'h00);
    reg_write(8'h03, 8'h80);
    reg_write(8'h04, 8'h00);
    run_until(e0 + 3 + 16);
    end_phase();
    stop_run();
    read_reg(8'h03, d); check("ftw_shadow", {24'd0, d}, 32'h0000_0080);

    // POFF=16 with FTW=0: constant ram[16]; then RUN=0
    reg_write(8'h03, 8'h00);
    reg_write(8'h04, 8'h00);
    reg_write(8'h05, 8'h10);
    reg_write(8'h06, 8'h00);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'h10);
    restart();
    run_until(e0 + 3 + 8);
    end_phase();
    bus.wr_en_i    = 1'b1;
    bus.reg_addr_i = 8'h00;
    bus.reg_data_i = 8'h00;
    cyc();
    bus.wr_en_i = 1'b0;
    read_reg(8'h08, d); check("stop_status_run", {24'd0, d}, 32'd2);
    check("stop_valid_still", {31'd0, sample_valid_o}, 32'd1);
    cyc();
    read_reg(8'h08, d); check("stop_status_idle", {24'd0, d}, 32'd0);
    check("stop_valid_drop", {31'd0, sample_valid_o}, 32'd0);
    check("stop_sample", {24'd0, sample_o}, 32'h0000_0010);
    repeat (2) cyc();
    check("idle_hold", {24'd0, sample_o}, 32'h0000_0010);
    reg_write(8'h05, 8'h00);

    // RAM overwrite during P2 read of 0x100: old value first, new on next pass
    reg_write(8'h04, 8'h01);
    for (int k = 0; k < 280; k++) exp_q.push_back(pat_sample(k, 1'b1));
    restart();
    run_until(e0 + 18);
    bus.wave_load_en_i = 1'b1;
    bus.wave_addr_i    = 12'h100;
    bus.wave_data_i    = 8'hAB;
    cyc();
    bus.wave_load_en_i = 1'b0;
    run_until(e0 + 3 + 280);
    end_phase();
    read_reg(8'h09, d); check("unmapped_09", {24'd0, d}, 32'd0);

    // Reset mid-run
    rst_n = 1'b0;
    #1;
    check("mid_rst_sample", {24'd0, sample_o}, 32'd0);
    check("mid_rst_valid", {31'd0, sample_valid_o}, 32'd0);
    read_reg(8'h07, d); check("mid_rst_amp", {24'd0, d}, 32'h0000_00FF);
    read_reg(8'h04, d); check("mid_rst_ftw", {24'd0, d}, 32'd0);
    read_reg(8'h00, d); check("mid_rst_ctrl", {24'd0, d}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) cyc();
    check("post_rst_valid", {31'd0, sample_valid_o}, 32'd0);
    read_reg(8'h08, d); check("post_rst_status", {24'd0, d}, 32'd0);

    // RAM contents survive reset (including the 0xAB overwrite)
    reg_write(8'h04, 8'h01);
    for (int k = 0; k < 20; k++) exp_q.push_back(pat_sample(k, 1'b0));
    restart();
    run_until(e0 + 3 + 20);
    end_phase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
